// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with a free-running scan mode.
// In DECODE mode the active output follows a loaded index. In SCAN mode
// the active output steps through every index, holding each one for
// dwell+1 cycles. All outputs come straight from flops.
module scan_decoder #(
  parameter  int SEL_W   = 2,
  parameter  int DWELL_W = 8,
  localparam int NOUT    = 2**SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               mode,
  input  logic               load,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [NOUT-1:0]    d_out,
  output logic [SEL_W-1:0]   cur_idx,
  output logic               wrap
);

  localparam logic MODE_DECODE = 1'b0;

  logic [SEL_W-1:0]   r_idx;
  logic [DWELL_W-1:0] r_cnt;
  logic [NOUT-1:0]    r_d_out;
  logic               r_wrap;

  logic [SEL_W-1:0]   w_next_idx;
  logic [DWELL_W-1:0] w_next_cnt;
  logic [NOUT-1:0]    w_next_d_out;
  logic               w_next_wrap;

  // Next index, dwell count and wrap flag, in priority order:
  // enable=0 freezes, then load, then DECODE hold, then the SCAN advance.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so a path
    // that leaves one unassigned cannot turn it into a latch.
    w_next_idx  = r_idx;
    w_next_cnt  = r_cnt;
    w_next_wrap = 1'b0;

    if (!enable) begin
      // Freeze: index and count keep their values, so the scan resumes
      // exactly where it stopped.
      w_next_idx = r_idx;
      w_next_cnt = r_cnt;
    end else if (load) begin
      w_next_idx = sel;
      w_next_cnt = '0;
    end else if (mode == MODE_DECODE) begin
      // The count is parked at zero so a later switch to SCAN starts a
      // fresh dwell from the current index.
      w_next_cnt = '0;
    end else if (r_cnt == dwell) begin
      // Index arithmetic wraps naturally in SEL_W bits.
      w_next_cnt  = '0;
      w_next_idx  = r_idx + 1'b1;
      w_next_wrap = (r_idx == '1);
    end else begin
      // If dwell was lowered below the count, the count runs on and
      // wraps modulo 2**DWELL_W until it meets the new dwell.
      w_next_cnt = r_cnt + 1'b1;
    end
  end

  // One-hot image of the next index, blanked while disabled.
  always_comb begin
    w_next_d_out = '0;
    if (enable) begin
      w_next_d_out[w_next_idx] = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_d_out <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_idx   <= w_next_idx;
      r_cnt   <= w_next_cnt;
      r_d_out <= w_next_d_out;
      r_wrap  <= w_next_wrap;
    end
  end

  assign d_out   = r_d_out;
  assign cur_idx = r_idx;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: a vector table for the basic
// decode/scan behaviour, hand-written multi-cycle sequences for the corner
// cases, and a randomized run against a behavioural model. A second
// instance with SEL_W=3 covers the wider output.
module tb_scan_decoder;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       mode;
  logic       load;
  logic [1:0] sel;
  logic [2:0] sel3;
  logic [7:0] dwell;

  logic [3:0] d_out;
  logic [1:0] cur_idx;
  logic       wrap;
  logic [7:0] d_out3;
  logic [2:0] cur_idx3;
  logic       wrap3;

  int n_cmp  = 0;
  int n_fail = 0;

  scan_decoder #(.SEL_W(2), .DWELL_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .load(load),
    .sel(sel), .dwell(dwell), .d_out(d_out), .cur_idx(cur_idx), .wrap(wrap)
  );

  scan_decoder #(.SEL_W(3), .DWELL_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .load(load),
    .sel(sel3), .dwell(dwell), .d_out(d_out3), .cur_idx(cur_idx3), .wrap(wrap3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: index, dwell count and expected outputs per instance,
  // kept as plain integers and updated from the documented per-edge rules.
  int m_idx  [2];
  int m_cnt  [2];
  int m_d    [2];
  int m_wrap [2];
  int m_nout [2] = '{4, 8};

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int s;
      s = (k == 0) ? int'(sel) : int'(sel3);
      m_wrap[k] = 0;
      if (!rst_n) begin
        m_idx[k] = 0;
        m_cnt[k] = 0;
        m_d[k]   = 0;
      end else if (!enable) begin
        m_d[k] = 0;
      end else begin
        if (load) begin
          m_idx[k] = s;
          m_cnt[k] = 0;
        end else if (!mode) begin
          m_cnt[k] = 0;
        end else if (m_cnt[k] == int'(dwell)) begin
          m_cnt[k]  = 0;
          m_wrap[k] = (m_idx[k] == m_nout[k] - 1) ? 1 : 0;
          m_idx[k]  = (m_idx[k] + 1) % m_nout[k];
        end else begin
          m_cnt[k] = (m_cnt[k] + 1) % 256;
        end
        m_d[k] = 1 << m_idx[k];
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic m,
                       input logic l, input logic [1:0] s,
                       input logic [7:0] dw);
    rst_n  = r;
    enable = e;
    mode   = m;
    load   = l;
    sel    = s;
    sel3   = {1'b0, s};
    dwell  = dw;
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       mode;
    logic       load;
    logic [1:0] sel;
    logic [7:0] dwell;
    logic [3:0] exp_d;
    logic [1:0] exp_idx;
    logic       exp_wrap;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic e, input logic m,
                              input logic l, input logic [1:0] s,
                              input logic [7:0] dw, input logic [3:0] d,
                              input logic [1:0] i, input logic w);
    vec_t v;
    v.rst_n = r; v.en = e; v.mode = m; v.load = l; v.sel = s; v.dwell = dw;
    v.exp_d = d; v.exp_idx = i; v.exp_wrap = w;
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    int n;

    // ---------------- vector table ----------------
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0000, 2'd0, 1'b0); // reset
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 8'd0, 4'b0100, 2'd2, 1'b0); // decode load 2
    vecs[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 8'd0, 4'b0100, 2'd2, 1'b0); // sel w/o load
    vecs[3]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 8'd0, 4'b0001, 2'd0, 1'b0); // decode load 0
    vecs[4]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'd0, 4'b0001, 2'd0, 1'b0); // scan load 0
    vecs[5]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 4'b0010, 2'd1, 1'b0); // dwell 0 steps
    vecs[6]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 4'b0100, 2'd2, 1'b0);
    vecs[7]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 4'b1000, 2'd3, 1'b0);
    vecs[8]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 4'b0001, 2'd0, 1'b1); // wrap
    vecs[9]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 4'b0010, 2'd1, 1'b0);
    vecs[10] = mk(1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 8'd0, 4'b0000, 2'd1, 1'b0); // blank, load ignored
    vecs[11] = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 8'd0, 4'b0010, 2'd1, 1'b0); // re-enable decode
    vecs[12] = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd2, 4'b0010, 2'd1, 1'b0); // scan, cnt 1
    vecs[13] = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd2, 4'b0010, 2'd1, 1'b0); // cnt 2
    vecs[14] = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd2, 4'b0100, 2'd2, 1'b0); // advance
    vecs[15] = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd2, 4'b0100, 2'd2, 1'b0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].mode, vecs[i].load,
            vecs[i].sel, vecs[i].dwell);
      step();
      check($sformatf("vec%0d_d_out", i), 32'(d_out), 32'(vecs[i].exp_d));
      check($sformatf("vec%0d_idx", i), 32'(cur_idx), 32'(vecs[i].exp_idx));
      check($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
    end

    // ---------------- dwell=3: 4 cycles per index, wrap every 16 ----------
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'd3);
    step();
    check("d3_load_d_out", 32'(d_out), 32'h1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd3);
    for (int k = 1; k <= 32; k++) begin
      step();
      check($sformatf("d3_k%0d_idx", k), 32'(cur_idx), 32'((k / 4) % 4));
      check($sformatf("d3_k%0d_d_out", k), 32'(d_out), 32'(1 << ((k / 4) % 4)));
      check($sformatf("d3_k%0d_wrap", k), 32'(wrap), 32'((k % 16) == 0));
    end

    // ---------------- mid-scan load ----------------
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 8'd3);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd3);
    step();
    step();
    check("ml_pre_idx", 32'(cur_idx), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 8'd3);
    step();
    check("ml_load_idx", 32'(cur_idx), 32'd3);
    check("ml_load_d_out", 32'(d_out), 32'h8);
    check("ml_load_wrap", 32'(wrap), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd3);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("ml_hold%0d_idx", k), 32'(cur_idx), 32'd3);
      check($sformatf("ml_hold%0d_wrap", k), 32'(wrap), 32'd0);
    end
    step();
    check("ml_wrap_idx", 32'(cur_idx), 32'd0);
    check("ml_wrap_wrap", 32'(wrap), 32'd1);
    check("ml_wrap_d_out", 32'(d_out), 32'h1);

    // ---------------- enable=0 freeze mid-dwell ----------------
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'd3);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd3);
    step();
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd3);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("fz%0d_d_out", k), 32'(d_out), 32'h0);
      check($sformatf("fz%0d_idx", k), 32'(cur_idx), 32'd0);
      check($sformatf("fz%0d_wrap", k), 32'(wrap), 32'd0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd3);
    step();
    check("fz_resume_d_out", 32'(d_out), 32'h1);
    step();
    check("fz_advance_d_out", 32'(d_out), 32'h2);
    check("fz_advance_idx", 32'(cur_idx), 32'd1);

    // ---------------- reset mid-scan ----------------
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 8'd3);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd3);
    step();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 8'd3);
    step();
    check("rst_d_out", 32'(d_out), 32'h0);
    check("rst_idx", 32'(cur_idx), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd3);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("rst_run%0d_d_out", k), 32'(d_out), 32'h1);
    end
    step();
    check("rst_adv_idx", 32'(cur_idx), 32'd1);
    check("rst_adv_d_out", 32'(d_out), 32'h2);

    // ---------------- dwell at maximum: 256 cycles per index ----------
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 8'd255);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd255);
    n = 0;
    do begin
      step();
      n++;
    end while (cur_idx == 2'd2 && n < 300);
    check("dmax_cycles", 32'(n), 32'd256);
    check("dmax_idx", 32'(cur_idx), 32'd3);

    // ---------------- dwell lowered below count: wraps, no lock-up ------
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'd10);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd10);
    for (int k = 0; k < 5; k++) step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd2);
    n = 0;
    do begin
      step();
      n++;
    end while (cur_idx == 2'd0 && n < 400);
    check("dlow_cycles", 32'(n), 32'd254);
    check("dlow_idx", 32'(cur_idx), 32'd1);

    // ---------------- SEL_W=3 instance: onehot(7) and wrap after 7 ------
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'd0);
    step();
    check("w3_load_d_out", 32'(d_out3), 32'h01);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("w3_k%0d_d_out", k), 32'(d_out3), 32'(1 << (k % 8)));
      check($sformatf("w3_k%0d_wrap", k), 32'(wrap3), 32'(k == 8));
      if (k == 7) check("w3_onehot7", 32'(d_out3), 32'h80);
    end

    // ---------------- randomized run against the model ----------------
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] dw;
      logic [2:0] s3;
      dw = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      s3 = 3'($urandom);
      rst_n  = ($urandom_range(0, 60) != 0);
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      load   = ($urandom_range(0, 9) == 0);
      sel    = s3[1:0];
      sel3   = s3;
      dwell  = dw;
      step();
      check("rnd_d_out", 32'(d_out), 32'(m_d[0]));
      check("rnd_idx", 32'(cur_idx), 32'(m_idx[0]));
      check("rnd_wrap", 32'(wrap), 32'(m_wrap[0]));
      check("rnd_d_out3", 32'(d_out3), 32'(m_d[1]));
      check("rnd_idx3", 32'(cur_idx3), 32'(m_idx[1]));
      check("rnd_wrap3", 32'(wrap3), 32'(m_wrap[1]));
      check("rnd_onehot", 32'($countones(d_out) <= 1), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
